// File: rtl/ld_req_arbiter_b2b.sv
// Load-request front end for the instruction-memory AXI read path.
// Captures toggle-signalled requests from NUM_SRC sources into per-source
// pending/holding registers, arbitrates them (fixed priority or round-robin)
// and issues one rd_start per request, routing rd_done back as src_done.
module ld_req_arbiter_b2b #(
  parameter int NUM_SRC        = 2,
  parameter int AXI_ADDR_WIDTH = 42,
  parameter int MEM_REQ_W      = 16,
  parameter int ARB_MODE       = 0,
  localparam int GID_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_SRC-1:0]                src_ld_req_in,
  input  logic [NUM_SRC*AXI_ADDR_WIDTH-1:0] src_ld_addr,
  input  logic [NUM_SRC*MEM_REQ_W-1:0]      src_ld_req_size,
  input  logic                              rd_buf_ready,
  input  logic                              rd_done,
  output logic                              rd_start,
  output logic [AXI_ADDR_WIDTH-1:0]         rd_addr,
  output logic [MEM_REQ_W-1:0]              rd_size,
  output logic [NUM_SRC-1:0]                src_done,
  output logic [GID_W-1:0]                  grant_id,
  output logic                              busy,
  output logic [NUM_SRC-1:0]                ovf_err
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RDY  = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [NUM_SRC-1:0]        req_prev_q, req_prev_d;
  logic [NUM_SRC-1:0]        pending_q, pending_d;
  logic [NUM_SRC-1:0]        ovf_q, ovf_d;
  logic [AXI_ADDR_WIDTH-1:0] hold_addr_q [NUM_SRC];
  logic [AXI_ADDR_WIDTH-1:0] hold_addr_d [NUM_SRC];
  logic [MEM_REQ_W-1:0]      hold_size_q [NUM_SRC];
  logic [MEM_REQ_W-1:0]      hold_size_d [NUM_SRC];
  logic [GID_W-1:0]          grant_q, grant_d;
  logic [GID_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [MEM_REQ_W-1:0]      rd_size_q, rd_size_d;
  logic                      rd_start_q, rd_start_d;
  logic [NUM_SRC-1:0]        src_done_q, src_done_d;

  logic [NUM_SRC-1:0]        edge_v;
  logic [NUM_SRC-1:0]        clr_v;
  logic [NUM_SRC-1:0]        capture_v;
  logic                      win_found;
  logic [GID_W-1:0]          win_idx;
  int                        rr_idx;

  // Pick the winning pending source: lowest index, or first after the RR pointer
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = 0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (pending_q[i]) begin
          win_found = 1'b1;
          win_idx   = GID_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        rr_idx = int'(rr_ptr_q) + k;
        if (rr_idx >= NUM_SRC) rr_idx = rr_idx - NUM_SRC;
        if (!win_found && pending_q[rr_idx]) begin
          win_found = 1'b1;
          win_idx   = GID_W'(rr_idx);
        end
      end
    end
  end

  // Toggle edge detect, pending capture and overflow; a set on the granted
  // source wins over the completion clear in the same cycle
  always_comb begin
    req_prev_d = src_ld_req_in;
    edge_v     = src_ld_req_in ^ req_prev_q;
    clr_v      = '0;
    if (state_q == ST_WAIT_DONE && rd_done) clr_v[grant_q] = 1'b1;
    capture_v  = edge_v & (~pending_q | clr_v);
    pending_d  = (pending_q & ~clr_v) | capture_v;
    ovf_d      = ovf_q | (edge_v & pending_q & ~clr_v);
    for (int i = 0; i < NUM_SRC; i++) begin
      hold_addr_d[i] = capture_v[i] ? src_ld_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]
                                    : hold_addr_q[i];
      hold_size_d[i] = capture_v[i] ? src_ld_req_size[i*MEM_REQ_W +: MEM_REQ_W]
                                    : hold_size_q[i];
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (win_found)    state_d = ST_WAIT_RDY;
      ST_WAIT_RDY:  if (rd_buf_ready) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (rd_done)      state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: latch the grant in IDLE, one start pulse, one done pulse
  always_comb begin
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    rd_addr_d  = rd_addr_q;
    rd_size_d  = rd_size_q;
    rd_start_d = 1'b0;
    src_done_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d   = win_idx;
          rd_addr_d = hold_addr_q[win_idx];
          rd_size_d = hold_size_q[win_idx];
        end
      end
      ST_WAIT_RDY:  rd_start_d = rd_buf_ready;
      ST_WAIT_DONE: begin
        if (rd_done) begin
          src_done_d = clr_v;
          rr_ptr_d   = grant_q;
        end
      end
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Control and output registers; the toggle history tracks the input during
  // reset so a level held across reset release is not seen as a request
  always_ff @(posedge clk) begin
    if (reset) begin
      req_prev_q <= src_ld_req_in;
      pending_q  <= '0;
      ovf_q      <= '0;
      grant_q    <= '0;
      rr_ptr_q   <= GID_W'(NUM_SRC - 1);
      rd_addr_q  <= '0;
      rd_size_q  <= '0;
      rd_start_q <= 1'b0;
      src_done_q <= '0;
    end else begin
      req_prev_q <= req_prev_d;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      rd_addr_q  <= rd_addr_d;
      rd_size_q  <= rd_size_d;
      rd_start_q <= rd_start_d;
      src_done_q <= src_done_d;
    end
  end

  // Per-source holding registers (data only, qualified by pending)
  always_ff @(posedge clk) begin
    hold_addr_q <= hold_addr_d;
    hold_size_q <= hold_size_d;
  end

  assign rd_start = rd_start_q;
  assign rd_addr  = rd_addr_q;
  assign rd_size  = rd_size_q;
  assign src_done = src_done_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != ST_IDLE);
  assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_ld_req_arbiter_b2b.sv
// Bench for ld_req_arbiter_b2b: one fixed-priority and one round-robin
// instance share request stimulus and are compared each cycle against a
// transaction-level reference model, plus directed literal checks.
module tb_ld_req_arbiter_b2b;
  localparam int NS = 2;
  localparam int AW = 42;
  localparam int SW = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [NS-1:0]    req_in;
  logic [NS*AW-1:0] addr_bus;
  logic [NS*SW-1:0] size_bus;
  logic             rdy;
  logic             done_r   [2];

  logic             o_start  [2];
  logic [AW-1:0]    o_addr   [2];
  logic [SW-1:0]    o_size   [2];
  logic [NS-1:0]    o_sdone  [2];
  logic [0:0]       o_gid    [2];
  logic             o_busy   [2];
  logic [NS-1:0]    o_ovf    [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model state (per instance m: 0 = fixed priority, 1 = round-robin)
  bit  [NS-1:0] m_prev;
  bit  [NS-1:0] m_pend  [2];
  logic [AW-1:0] m_haddr [2][NS];
  logic [SW-1:0] m_hsize [2][NS];
  bit  [NS-1:0] m_ovf   [2];
  int           m_phase [2];
  int           m_gid   [2];
  int           m_ptr   [2];
  logic [AW-1:0] m_raddr [2];
  logic [SW-1:0] m_rsize [2];
  bit           m_start [2];
  bit  [NS-1:0] m_sdone [2];
  bit           m_valid = 1'b0;

  always #5 clk = ~clk;

  ld_req_arbiter_b2b #(.NUM_SRC(NS), .AXI_ADDR_WIDTH(AW), .MEM_REQ_W(SW), .ARB_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .src_ld_req_in(req_in), .src_ld_addr(addr_bus),
    .src_ld_req_size(size_bus), .rd_buf_ready(rdy), .rd_done(done_r[0]),
    .rd_start(o_start[0]), .rd_addr(o_addr[0]), .rd_size(o_size[0]),
    .src_done(o_sdone[0]), .grant_id(o_gid[0]), .busy(o_busy[0]), .ovf_err(o_ovf[0]));

  ld_req_arbiter_b2b #(.NUM_SRC(NS), .AXI_ADDR_WIDTH(AW), .MEM_REQ_W(SW), .ARB_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .src_ld_req_in(req_in), .src_ld_addr(addr_bus),
    .src_ld_req_size(size_bus), .rd_buf_ready(rdy), .rd_done(done_r[1]),
    .rd_start(o_start[1]), .rd_addr(o_addr[1]), .rd_size(o_size[1]),
    .src_done(o_sdone[1]), .grant_id(o_gid[1]), .busy(o_busy[1]), .ovf_err(o_ovf[1]));

  function automatic int pick(int m);
    int j;
    if (m == 0) begin
      for (int i = 0; i < NS; i++) if (m_pend[m][i]) return i;
    end else begin
      for (int k = 1; k <= NS; k++) begin
        j = (m_ptr[m] + k) % NS;
        if (m_pend[m][j]) return j;
      end
    end
    return 0;
  endfunction

  // advance the model by one clock using the inputs that the next edge samples
  task automatic model_step();
    bit [NS-1:0] e;
    bit clr_hit;
    int w;
    e = req_in ^ m_prev;
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        m_pend[m] = '0; m_ovf[m] = '0; m_phase[m] = 0; m_gid[m] = 0;
        m_ptr[m] = NS - 1; m_raddr[m] = '0; m_rsize[m] = '0;
        m_start[m] = 1'b0; m_sdone[m] = '0;
      end
      m_prev  = req_in;
      m_valid = 1'b1;
      return;
    end
    for (int m = 0; m < 2; m++) begin
      clr_hit    = 1'b0;
      m_start[m] = 1'b0;
      m_sdone[m] = '0;
      if (m_phase[m] == 0) begin
        if (m_pend[m] != 0) begin
          w = pick(m);
          m_gid[m] = w; m_raddr[m] = m_haddr[m][w]; m_rsize[m] = m_hsize[m][w];
          m_phase[m] = 1;
        end
      end else if (m_phase[m] == 1) begin
        if (rdy) begin m_start[m] = 1'b1; m_phase[m] = 2; end
      end else begin
        if (done_r[m]) begin
          clr_hit = 1'b1;
          m_sdone[m][m_gid[m]] = 1'b1;
          m_ptr[m] = m_gid[m];
          m_phase[m] = 0;
        end
      end
      for (int i = 0; i < NS; i++) begin
        if (e[i]) begin
          if (!m_pend[m][i] || (clr_hit && m_gid[m] == i)) begin
            m_pend[m][i]  = 1'b1;
            m_haddr[m][i] = addr_bus[i*AW +: AW];
            m_hsize[m][i] = size_bus[i*SW +: SW];
          end else begin
            m_ovf[m][i] = 1'b1;
          end
        end else if (clr_hit && m_gid[m] == i) begin
          m_pend[m][i] = 1'b0;
        end
      end
    end
    m_prev = req_in;
  endtask

  // compare process: every negedge, DUT outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (m_valid) begin
        for (int m = 0; m < 2; m++) begin
          n_vec++;
          if ({o_start[m], o_addr[m], o_size[m], o_sdone[m], o_gid[m], o_busy[m], o_ovf[m]} !==
              {m_start[m], m_raddr[m], m_rsize[m], m_sdone[m], 1'(m_gid[m]), (m_phase[m] != 0), m_ovf[m]}) begin
            n_err++;
            $display("FAIL model cyc%0d dut%0d: got start=%b addr=%h size=%h done=%b gid=%0d busy=%b ovf=%b; want start=%b addr=%h size=%h done=%b gid=%0d busy=%b ovf=%b",
                     cyc, m, o_start[m], o_addr[m], o_size[m], o_sdone[m], o_gid[m], o_busy[m], o_ovf[m],
                     m_start[m], m_raddr[m], m_rsize[m], m_sdone[m], m_gid[m], (m_phase[m] != 0), m_ovf[m]);
          end
        end
      end
      model_step();
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic toggle(int i, logic [AW-1:0] a, logic [SW-1:0] s);
    addr_bus[i*AW +: AW] = a;
    size_bus[i*SW +: SW] = s;
    req_in[i] = ~req_in[i];
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (o_start[0]) begin ok = 1'b1; break; end
      step(1);
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL wait_start: rd_start=0 after 40 cycles, expected 1");
    end
  endtask

  task automatic serve(output int g0, output int g1, output logic [AW-1:0] a0);
    bit ok;
    wait_start(ok);
    g0 = int'(o_gid[0]); g1 = int'(o_gid[1]); a0 = o_addr[0];
    done_r[0] = 1'b1; done_r[1] = 1'b1;
    step(1);
    done_r[0] = 1'b0; done_r[1] = 1'b0;
  endtask

  initial begin
    int g0, g1;
    logic [AW-1:0] a0;
    logic [63:0] r;
    bit ok;
    reset = 1'b1; req_in = '0; addr_bus = '0; size_bus = '0; rdy = 1'b0;
    done_r[0] = 1'b0; done_r[1] = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);
    chk("reset_start", 64'(o_start[0]), 64'd0);
    chk("reset_busy",  64'(o_busy[0]),  64'd0);
    chk("reset_ovf",   64'(o_ovf[0]),   64'd0);
    chk("reset_addr",  64'(o_addr[0]),  64'd0);

    // single request
    rdy = 1'b1;
    toggle(0, 42'h1000, 16'd256);
    step(1);
    chk("single_busy_k", 64'(o_busy[0]), 64'd0);
    step(1);
    chk("single_busy_k1", 64'(o_busy[0]), 64'd1);
    chk("single_start_k1", 64'(o_start[0]), 64'd0);
    step(1);
    chk("single_start", 64'(o_start[0]), 64'd1);
    chk("single_addr",  64'(o_addr[0]),  64'h1000);
    chk("single_size",  64'(o_size[0]),  64'd256);
    done_r[0] = 1'b1; done_r[1] = 1'b1;
    step(1);
    done_r[0] = 1'b0; done_r[1] = 1'b0;
    chk("single_start_once", 64'(o_start[0]), 64'd0);
    chk("single_src_done", 64'(o_sdone[0]), 64'b01);
    chk("single_idle", 64'(o_busy[0]), 64'd0);
    step(1);

    // back-pressure
    rdy = 1'b0;
    toggle(0, 42'h2000, 16'd64);
    step(2);
    for (int c = 0; c < 10; c++) begin
      chk("bp_no_start", 64'(o_start[0]), 64'd0);
      chk("bp_addr", 64'(o_addr[0]), 64'h2000);
      step(1);
    end
    rdy = 1'b1;
    step(1);
    chk("bp_start", 64'(o_start[0]), 64'd1);
    step(1);
    chk("bp_start_once", 64'(o_start[0]), 64'd0);
    done_r[0] = 1'b1; done_r[1] = 1'b1;
    step(1);
    done_r[0] = 1'b0; done_r[1] = 1'b0;
    step(1);

    // simultaneous toggles, three rounds: fixed 0,1; round-robin 1,0 (pointer at 0)
    for (int rnd = 0; rnd < 3; rnd++) begin
      toggle(0, 42'h100, 16'd1);
      toggle(1, 42'h200, 16'd2);
      serve(g0, g1, a0);
      chk("arb_first_fp", 64'(g0), 64'd0);
      chk("arb_first_rr", 64'(g1), 64'd1);
      chk("arb_first_addr", 64'(a0), 64'h100);
      serve(g0, g1, a0);
      chk("arb_second_fp", 64'(g0), 64'd1);
      chk("arb_second_rr", 64'(g1), 64'd0);
      chk("arb_second_addr", 64'(a0), 64'h200);
    end
    step(2);

    // overflow on source 1
    rdy = 1'b0;
    toggle(1, 42'h20, 16'd8);
    step(1);
    toggle(1, 42'h40, 16'd9);
    step(1);
    chk("ovf_fp", 64'(o_ovf[0]), 64'b10);
    chk("ovf_rr", 64'(o_ovf[1]), 64'b10);
    rdy = 1'b1;
    serve(g0, g1, a0);
    chk("ovf_addr", 64'(a0), 64'h20);
    step(3);
    chk("ovf_single_serve", 64'(o_busy[0]), 64'd0);
    chk("ovf_sticky", 64'(o_ovf[0]), 64'b10);

    // done/set collision on source 0
    toggle(0, 42'h300, 16'd3);
    wait_start(ok);
    done_r[0] = 1'b1; done_r[1] = 1'b1;
    toggle(0, 42'h80, 16'd4);
    step(1);
    done_r[0] = 1'b0; done_r[1] = 1'b0;
    chk("coll_src_done", 64'(o_sdone[0]), 64'b01);
    chk("coll_no_ovf", 64'(o_ovf[0]), 64'b10);
    serve(g0, g1, a0);
    chk("coll_addr", 64'(a0), 64'h80);
    step(2);

    // reset with request level changed and held through release
    reset = 1'b1;
    req_in = req_in ^ 2'b11;
    step(2);
    reset = 1'b0;
    step(6);
    chk("rst_no_req_busy", 64'(o_busy[0]), 64'd0);
    chk("rst_no_req_start", 64'(o_start[0]), 64'd0);
    chk("rst_ovf_clear", 64'(o_ovf[0]), 64'd0);
    // reset asserted in WAIT_DONE together with rd_done
    toggle(1, 42'h500, 16'd5);
    wait_start(ok);
    reset = 1'b1; done_r[0] = 1'b1; done_r[1] = 1'b1;
    step(1);
    chk("rst_mid_start", 64'(o_start[0]), 64'd0);
    chk("rst_mid_done", 64'(o_sdone[0]), 64'd0);
    chk("rst_mid_busy", 64'(o_busy[0]), 64'd0);
    chk("rst_mid_addr", 64'(o_addr[0]), 64'd0);
    chk("rst_mid_gid", 64'(o_gid[0]), 64'd0);
    reset = 1'b0; done_r[0] = 1'b0; done_r[1] = 1'b0;
    step(2);

    // randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NS; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          r = {$urandom(), $urandom()};
          toggle(i, r[AW-1:0], SW'($urandom_range(0, 65535)));
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      done_r[0] = ($urandom_range(0, 2) == 0);
      done_r[1] = ($urandom_range(0, 2) == 0);
      step(1);
    end
    reset = 1'b0; rdy = 1'b0; done_r[0] = 1'b0; done_r[1] = 1'b0;
    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
